// File: rtl/aer_out_decoder.sv
// aer_out_decoder
// Receiver for the 4-phase AER link from the SNN output layer. Every event
// is synchronized and acknowledged. Spikes are counted per output neuron and
// the inferred class is decided either by an immediate spike-threshold win
// or by an argmax scan once the encoder has finished and the link is quiet.
// INFERENCE_DONE pulses for one cycle when the class is decided.
module aer_out_decoder #(
    parameter int N_NEURONS       = 10,
    parameter int ADDR_BITS       = 8,
    parameter int COUNT_BITS      = 8,
    parameter int SPIKE_THRESHOLD = 32,
    parameter int TIMEOUT_CYCLES  = 1024,
    parameter int CLASS_BITS      = $clog2(N_NEURONS)
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [ADDR_BITS-1:0]  AEROUT_ADDR,
    input  logic                  AEROUT_REQ,
    output logic                  AEROUT_ACK,
    input  logic                  NEW_IMAGE,
    input  logic                  IMAGE_ENCODED,
    output logic                  INFERENCE_DONE,
    output logic [CLASS_BITS-1:0] INFERRED_CLASS,
    output logic [COUNT_BITS-1:0] WINNER_COUNT
);

    localparam int TIMER_BITS = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [COUNT_BITS-1:0] CNT_MAX  = '1;
    localparam logic [COUNT_BITS-1:0] CNT_THR  = COUNT_BITS'(SPIKE_THRESHOLD);
    localparam logic [TIMER_BITS-1:0] TMO_LAST = TIMER_BITS'(TIMEOUT_CYCLES - 1);
    localparam logic [CLASS_BITS-1:0] IDX_LAST = CLASS_BITS'(N_NEURONS - 1);

    // Handshake FSM states
    localparam logic HS_WAIT_REQ = 1'b0;
    localparam logic HS_WAIT_REL = 1'b1;

    // Inference FSM states
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_RUN    = 3'd1;
    localparam logic [2:0] S_DRAIN  = 3'd2;
    localparam logic [2:0] S_ARGMAX = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    // Request synchronizer and handshake
    logic                  r_req_s1;
    logic                  r_req_s2;
    logic                  r_hs_state;
    logic                  r_ack;
    logic                  r_evt_valid;
    logic [ADDR_BITS-1:0]  r_addr;

    // Spike counters and inference state
    logic [COUNT_BITS-1:0] r_cnt [N_NEURONS];
    logic [2:0]            r_state;
    logic [TIMER_BITS-1:0] r_timer;
    logic [CLASS_BITS-1:0] r_idx;
    logic [CLASS_BITS-1:0] r_cand_class;
    logic [COUNT_BITS-1:0] r_cand_cnt;
    logic                  r_done;
    logic [CLASS_BITS-1:0] r_class;
    logic [COUNT_BITS-1:0] r_win_cnt;

    // Combinational helpers
    logic                  w_addr_ok;
    logic [COUNT_BITS-1:0] w_cur_cnt;
    logic [COUNT_BITS-1:0] w_inc_cnt;
    logic [COUNT_BITS-1:0] w_scan_cnt;
    logic                  w_counting;
    logic                  w_count_en;
    logic                  w_thr_hit;
    logic [CLASS_BITS-1:0] w_evt_class;

    // Two-flop synchronizer for the asynchronous request line
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_req_s1 <= 1'b0;
            r_req_s2 <= 1'b0;
        end else begin
            r_req_s1 <= AEROUT_REQ;
            r_req_s2 <= r_req_s1;
        end
    end

    // 4-phase handshake: acknowledge every request regardless of inference state
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_hs_state  <= HS_WAIT_REQ;
            r_ack       <= 1'b0;
            r_evt_valid <= 1'b0;
        end else begin
            r_evt_valid <= 1'b0;
            case (r_hs_state)
                HS_WAIT_REQ: begin
                    if (r_req_s2) begin
                        r_ack       <= 1'b1;
                        r_evt_valid <= 1'b1;
                        r_hs_state  <= HS_WAIT_REL;
                    end
                end
                default: begin
                    if (!r_req_s2) begin
                        r_ack      <= 1'b0;
                        r_hs_state <= HS_WAIT_REQ;
                    end
                end
            endcase
        end
    end

    // Address capture; the sender holds it stable while REQ is high
    always_ff @(posedge CLK) begin
        if (r_hs_state == HS_WAIT_REQ && r_req_s2) begin
            r_addr <= AEROUT_ADDR;
        end
    end

    // Decode the event address and form the saturating incremented count
    always_comb begin
        w_addr_ok = 1'b0;
        w_cur_cnt = '0;
        for (int i = 0; i < N_NEURONS; i++) begin
            if (r_addr == ADDR_BITS'(i)) begin
                w_addr_ok = 1'b1;
                w_cur_cnt = r_cnt[i];
            end
        end
        w_inc_cnt   = (w_cur_cnt == CNT_MAX) ? CNT_MAX : w_cur_cnt + COUNT_BITS'(1);
        w_evt_class = CLASS_BITS'(r_addr);
        w_counting  = (r_state == S_RUN) || (r_state == S_DRAIN);
        w_count_en  = r_evt_valid && w_addr_ok && w_counting;
        w_thr_hit   = w_count_en && (w_inc_cnt == CNT_THR);
    end

    // Counter selected by the argmax scan index
    always_comb begin
        w_scan_cnt = '0;
        for (int i = 0; i < N_NEURONS; i++) begin
            if (r_idx == CLASS_BITS'(i)) begin
                w_scan_cnt = r_cnt[i];
            end
        end
    end

    // Per-neuron spike counters; NEW_IMAGE clears them but keeps a coincident event
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < N_NEURONS; i++) begin
                r_cnt[i] <= '0;
            end
        end else if (NEW_IMAGE) begin
            for (int i = 0; i < N_NEURONS; i++) begin
                r_cnt[i] <= (r_evt_valid && r_addr == ADDR_BITS'(i)) ?
                            COUNT_BITS'(1) : '0;
            end
        end else if (w_count_en) begin
            for (int i = 0; i < N_NEURONS; i++) begin
                if (r_addr == ADDR_BITS'(i)) begin
                    r_cnt[i] <= w_inc_cnt;
                end
            end
        end
    end

    // Inference FSM: threshold win, quiet-link timeout, argmax scan, result latch
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state      <= S_IDLE;
            r_timer      <= '0;
            r_idx        <= '0;
            r_cand_class <= '0;
            r_cand_cnt   <= '0;
            r_done       <= 1'b0;
            r_class      <= '0;
            r_win_cnt    <= '0;
        end else begin
            r_done <= 1'b0;
            if (NEW_IMAGE) begin
                r_state      <= S_RUN;
                r_timer      <= '0;
                r_idx        <= '0;
                r_cand_class <= '0;
                r_cand_cnt   <= '0;
                r_class      <= '0;
                r_win_cnt    <= '0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_state <= S_IDLE;
                    end
                    S_RUN: begin
                        if (w_thr_hit) begin
                            r_cand_class <= w_evt_class;
                            r_cand_cnt   <= w_inc_cnt;
                            r_state      <= S_DONE;
                        end else if (IMAGE_ENCODED) begin
                            r_timer <= '0;
                            r_state <= S_DRAIN;
                        end
                    end
                    S_DRAIN: begin
                        if (w_thr_hit) begin
                            r_cand_class <= w_evt_class;
                            r_cand_cnt   <= w_inc_cnt;
                            r_state      <= S_DONE;
                        end else if (w_count_en) begin
                            // Any counted spike restarts the quiet-link window
                            r_timer <= '0;
                        end else if (r_timer == TMO_LAST) begin
                            r_idx        <= '0;
                            r_cand_class <= '0;
                            r_cand_cnt   <= '0;
                            r_state      <= S_ARGMAX;
                        end else begin
                            r_timer <= r_timer + TIMER_BITS'(1);
                        end
                    end
                    S_ARGMAX: begin
                        // Strict compare keeps the lowest index on ties and
                        // leaves class 0 / count 0 when nothing spiked
                        if (w_scan_cnt > r_cand_cnt) begin
                            r_cand_class <= r_idx;
                            r_cand_cnt   <= w_scan_cnt;
                        end
                        if (r_idx == IDX_LAST) begin
                            r_state <= S_DONE;
                        end else begin
                            r_idx <= r_idx + CLASS_BITS'(1);
                        end
                    end
                    S_DONE: begin
                        r_done    <= 1'b1;
                        r_class   <= r_cand_class;
                        r_win_cnt <= r_cand_cnt;
                        r_state   <= S_IDLE;
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign AEROUT_ACK     = r_ack;
    assign INFERENCE_DONE = r_done;
    assign INFERRED_CLASS = r_class;
    assign WINNER_COUNT   = r_win_cnt;

endmodule

// File: tb/tb_aer_out_decoder.sv
// tb_aer_out_decoder
// Drives AER events into two decoder instances sharing one stimulus bus:
// a default-parameter instance and a narrow-counter instance (COUNT_BITS=4,
// SPIKE_THRESHOLD=15). Expected results are queued when stimulus is issued
// and popped by per-instance monitors when INFERENCE_DONE pulses.
module tb_aer_out_decoder;

    localparam int N_N   = 10;
    localparam int T_M   = 1024;
    localparam int T_S   = 16;
    localparam int LIMIT = 3000;

    typedef struct {
        logic [3:0] cls;
        logic [7:0] cnt;
    } exp_t;

    typedef struct {
        logic [7:0] a0;
        int         n0;
        logic [7:0] a1;
        int         n1;
        logic       thr;
        logic [3:0] cls;
        logic [7:0] cnt;
    } vec_t;

    logic       CLK;
    logic       RST;
    logic [7:0] ADDR;
    logic       REQ;
    logic       NI;
    logic       ENC;

    logic       ack_m;
    logic       done_m;
    logic [3:0] cls_m;
    logic [7:0] cnt_m;
    logic       ack_s;
    logic       done_s;
    logic [3:0] cls_s;
    logic [3:0] cnt_s;

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   last_ack_cyc = 0;
    int   done_cyc_m = 0;
    int   done_cyc_s = 0;
    int   done_cnt_m = 0;
    int   done_cnt_s = 0;
    logic use_s = 1'b0;
    logic mon_en_m = 1'b0;
    logic mon_en_s = 1'b0;

    exp_t q_m[$];
    exp_t q_s[$];
    exp_t em;
    exp_t es;
    vec_t vecs[7];

    aer_out_decoder #(
        .N_NEURONS(N_N), .ADDR_BITS(8), .COUNT_BITS(8),
        .SPIKE_THRESHOLD(32), .TIMEOUT_CYCLES(T_M)
    ) u_dut_m (
        .CLK(CLK), .RST(RST), .AEROUT_ADDR(ADDR), .AEROUT_REQ(REQ),
        .AEROUT_ACK(ack_m), .NEW_IMAGE(NI), .IMAGE_ENCODED(ENC),
        .INFERENCE_DONE(done_m), .INFERRED_CLASS(cls_m), .WINNER_COUNT(cnt_m)
    );

    aer_out_decoder #(
        .N_NEURONS(N_N), .ADDR_BITS(8), .COUNT_BITS(4),
        .SPIKE_THRESHOLD(15), .TIMEOUT_CYCLES(T_S)
    ) u_dut_s (
        .CLK(CLK), .RST(RST), .AEROUT_ADDR(ADDR), .AEROUT_REQ(REQ),
        .AEROUT_ACK(ack_s), .NEW_IMAGE(NI), .IMAGE_ENCODED(ENC),
        .INFERENCE_DONE(done_s), .INFERRED_CLASS(cls_s), .WINNER_COUNT(cnt_s)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor for the default instance
    always begin
        @(posedge CLK);
        #1;
        if (mon_en_m && done_m) begin
            done_cnt_m++;
            done_cyc_m = cyc;
            if (q_m.size() == 0) begin
                chk("unexpected_done_m", 1, 0);
            end else begin
                em = q_m.pop_front();
                chk("class_m", int'(cls_m), int'(em.cls));
                chk("count_m", int'(cnt_m), int'(em.cnt));
            end
        end
    end

    // Monitor for the narrow-counter instance
    always begin
        @(posedge CLK);
        #1;
        if (mon_en_s && done_s) begin
            done_cnt_s++;
            done_cyc_s = cyc;
            if (q_s.size() == 0) begin
                chk("unexpected_done_s", 1, 0);
            end else begin
                es = q_s.pop_front();
                chk("class_s", int'(cls_s), int'(es.cls));
                chk("count_s", int'(cnt_s), int'(es.cnt));
            end
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge CLK);
    endtask

    // Cycles (posedges) until the selected ACK reaches lvl; 99 when it never does
    task automatic wait_ack(input logic lvl, output int lat);
        logic seen;
        seen = 1'b0;
        lat  = 99;
        for (int c = 1; c <= 20; c++) begin
            if (!seen) begin
                @(posedge CLK);
                #1;
                if ((use_s ? ack_s : ack_m) == lvl) begin
                    lat  = c;
                    seen = 1'b1;
                end
            end
        end
    endtask

    task automatic send_event(input logic [7:0] a);
        int lat;
        @(negedge CLK);
        ADDR = a;
        REQ  = 1'b1;
        wait_ack(1'b1, lat);
        chk("ack_rise_lat", lat, 3);
        last_ack_cyc = cyc;
        @(negedge CLK);
        REQ = 1'b0;
        wait_ack(1'b0, lat);
        chk("ack_fall_lat", lat, 3);
    endtask

    task automatic pulse_ni();
        @(negedge CLK);
        NI = 1'b1;
        @(negedge CLK);
        NI = 1'b0;
    endtask

    task automatic wait_done_m();
        for (int c = 0; c < LIMIT; c++) begin
            if (q_m.size() != 0) begin
                @(posedge CLK);
                #2;
            end
        end
        chk("done_seen_m", q_m.size(), 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int   lat;
        int   ref_cyc;
        int   exp_lat;
        int   d0;
        int   sat_ref;
        int   i0;
        int   i1;
        exp_t e;

        RST = 1'b0; REQ = 1'b0; NI = 1'b0; ENC = 1'b0; ADDR = 8'd0;
        ref_cyc = 0; sat_ref = 0;

        vecs[0] = '{8'd3,   1, 8'd0,   0, 1'b0, 4'd3, 8'd1};
        vecs[1] = '{8'd7,  32, 8'd2,   5, 1'b1, 4'd7, 8'd32};
        vecs[2] = '{8'd1,   4, 8'd5,   4, 1'b0, 4'd1, 8'd4};
        vecs[3] = '{8'd12,  1, 8'd255, 1, 1'b0, 4'd0, 8'd0};
        vecs[4] = '{8'd9,   3, 8'd4,   6, 1'b0, 4'd4, 8'd6};
        vecs[5] = '{8'd9,   2, 8'd0,   0, 1'b0, 4'd9, 8'd2};
        vecs[6] = '{8'd3,   5, 8'd8,   5, 1'b0, 4'd3, 8'd5};

        // Reset state
        wait_cycles(3);
        #1;
        chk("reset_ack_m", int'(ack_m), 0);
        chk("reset_done_m", int'(done_m), 0);
        chk("reset_class_m", int'(cls_m), 0);
        chk("reset_count_m", int'(cnt_m), 0);
        chk("reset_ack_s", int'(ack_s), 0);
        @(negedge CLK);
        RST = 1'b1;
        mon_en_m = 1'b1;

        // Table-driven inferences on the default instance
        for (int v = 0; v < 7; v++) begin
            ENC = 1'b0;
            pulse_ni();
            chk("ni_clears_class", int'(cls_m), 0);
            chk("ni_clears_count", int'(cnt_m), 0);
            e.cls = vecs[v].cls;
            e.cnt = vecs[v].cnt;
            q_m.push_back(e);
            i0 = 0;
            i1 = 0;
            while (i0 < vecs[v].n0 || i1 < vecs[v].n1) begin
                if (i0 < vecs[v].n0) begin
                    send_event(vecs[v].a0);
                    i0++;
                end
                if (i1 < vecs[v].n1) begin
                    send_event(vecs[v].a1);
                    i1++;
                end
            end
            if (vecs[v].thr) begin
                ref_cyc = last_ack_cyc;
                exp_lat = 2;
            end else begin
                @(negedge CLK);
                ENC     = 1'b1;
                ref_cyc = cyc + 1;
                exp_lat = T_M + N_N + 1;
            end
            wait_done_m();
            chk("done_latency", done_cyc_m - ref_cyc, exp_lat);
            wait_cycles(3);
            #1;
            chk("held_class", int'(cls_m), int'(vecs[v].cls));
            chk("held_count", int'(cnt_m), int'(vecs[v].cnt));
            @(negedge CLK);
            ENC = 1'b0;
        end

        // Reset asserted while ACK is high, REQ still held through reset
        @(negedge CLK);
        ADDR = 8'd5;
        REQ  = 1'b1;
        wait_ack(1'b1, lat);
        chk("pre_reset_ack_lat", lat, 3);
        @(negedge CLK);
        RST = 1'b0;
        #1;
        chk("reset_drops_ack_m", int'(ack_m), 0);
        chk("reset_drops_ack_s", int'(ack_s), 0);
        chk("reset_clears_class", int'(cls_m), 0);
        chk("reset_clears_count", int'(cnt_m), 0);
        @(negedge CLK);
        RST = 1'b1;
        wait_ack(1'b1, lat);
        chk("post_reset_reack_lat", lat, 3);
        @(negedge CLK);
        REQ = 1'b0;
        wait_ack(1'b0, lat);
        chk("post_reset_fall_lat", lat, 3);

        // NEW_IMAGE while draining: no result for the aborted image
        pulse_ni();
        send_event(8'd6);
        send_event(8'd6);
        send_event(8'd6);
        @(negedge CLK);
        ENC = 1'b1;
        wait_cycles(20);
        @(negedge CLK);
        ENC = 1'b0;
        NI  = 1'b1;
        @(negedge CLK);
        NI = 1'b0;
        d0 = done_cnt_m;
        e.cls = 4'd2;
        e.cnt = 8'd1;
        q_m.push_back(e);
        send_event(8'd2);
        @(negedge CLK);
        ENC     = 1'b1;
        ref_cyc = cyc + 1;
        wait_done_m();
        chk("abort_done_latency", done_cyc_m - ref_cyc, T_M + N_N + 1);
        chk("abort_single_done", done_cnt_m, d0 + 1);
        @(negedge CLK);
        ENC = 1'b0;

        // NEW_IMAGE in the same cycle as an event: that event counts as 1
        pulse_ni();
        send_event(8'd4);
        send_event(8'd4);
        send_event(8'd4);
        e.cls = 4'd8;
        e.cnt = 8'd1;
        q_m.push_back(e);
        @(negedge CLK);
        ADDR = 8'd8;
        REQ  = 1'b1;
        wait_ack(1'b1, lat);
        chk("coinc_ack_rise_lat", lat, 3);
        @(negedge CLK);
        NI = 1'b1;
        @(negedge CLK);
        NI  = 1'b0;
        REQ = 1'b0;
        wait_ack(1'b0, lat);
        chk("coinc_ack_fall_lat", lat, 3);
        @(negedge CLK);
        ENC     = 1'b1;
        ref_cyc = cyc + 1;
        wait_done_m();
        chk("coinc_done_latency", done_cyc_m - ref_cyc, T_M + N_N + 1);
        @(negedge CLK);
        ENC = 1'b0;

        // Narrow counters: threshold equals counter max, later IDLE events ignored
        mon_en_m = 1'b0;
        use_s    = 1'b1;
        mon_en_s = 1'b1;
        pulse_ni();
        e.cls = 4'd0;
        e.cnt = 8'd15;
        q_s.push_back(e);
        for (int k = 1; k <= 20; k++) begin
            send_event(8'd0);
            if (k == 15) sat_ref = last_ack_cyc;
        end
        wait_cycles(5);
        #1;
        chk("sat_done_seen", q_s.size(), 0);
        chk("sat_done_pulses", done_cnt_s, 1);
        chk("sat_done_latency", done_cyc_s - sat_ref, 2);
        chk("sat_held_class", int'(cls_s), 0);
        chk("sat_held_count", int'(cnt_s), 15);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
